request_encoder: RTL
====================

REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 Parameters: none; sizes SHALL be fixed by package constants NUM_REQ=4 and ADDR_W=2.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 enable  input  1  permits a new capture when high.
REQ-005 in0, in1, in2, in3  input  1 each  level request lines; index n is the line a decoder drives as outn.
REQ-006 ready  input  1  consumer accepts the held code when high together with valid.
REQ-007 address0, address1  output  1 each  registered code of the granted line (address1 = MSB).
REQ-008 valid  output  1  the held code is meaningful.
REQ-009 multi  output  1  more than one request line was high at the capture edge.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (valid=0) and HOLD (valid=1).
REQ-011 IDLE: at an edge with enable=1 and any inN=1, the block SHALL capture the winner's index into address1:address0, set multi, and go to HOLD; otherwise it SHALL stay in IDLE with outputs unchanged.
REQ-012 Latency: a request sampled at edge N SHALL show valid=1 in the cycle after edge N; there is no combinational path from in0..in3 to any output.
REQ-013 HOLD: address0, address1 and multi SHALL remain stable while ready=0, whatever in0..in3 and enable do.
REQ-014 HOLD, ready=1: the code is consumed at that edge. If enable=1 and any request is high, the block SHALL capture a new winner at the same edge and stay in HOLD (back-to-back, no bubble). Otherwise it SHALL go to IDLE with valid=0.
REQ-015 In IDLE, ready SHALL be ignored.
REQ-016 Requests are level: a line still high after being granted SHALL compete again at the next capture.
REQ-017 multi SHALL be 1 when the popcount of in0..in3 is at least 2 at the capture edge, and 0 otherwise.
REQ-018 In IDLE, address0, address1 and multi SHALL keep the last captured values and are don't-care to consumers.

Reset
REQ-019 reset=1 SHALL immediately force IDLE, valid=0, address0=0, address1=0, multi=0, and round-robin pointer=0, including in the middle of HOLD.
REQ-020 The first capture after reset is released SHALL be evaluated at the first rising edge with reset=0.

Configuration
REQ-021 Macro REQUEST_ENCODER_RR_EN selects the arbitration mode.
REQ-022 With REQUEST_ENCODER_RR_EN defined:
- a 2-bit pointer selects the starting point of the winner search, ptr, ptr+1, ... modulo 4;
- on every consumed grant (valid and ready), the pointer SHALL become the granted index + 1, modulo 4 (3 wraps to 0).
REQ-023 With REQUEST_ENCODER_RR_EN undefined:
- fixed priority applies and the lowest index wins;
- no pointer register SHALL exist.

Structure
REQ-024 A shared package SHALL hold NUM_REQ, ADDR_W and the state enum {IDLE, HOLD}.
REQ-025 A combinational sub-module priority_pick4 SHALL take the 4 request lines plus a 2-bit start index and return the winner index, an any flag and the multi flag; in fixed mode the start index SHALL be tied to 0.

Verification
REQ-026 Reset mid-HOLD: with valid=1, assert reset asynchronously -> valid=0 and address1:address0=00 before the next clk edge.
REQ-027 Single request: in2=1, enable=1 at edge N -> from edge N: valid=1, address1:address0=10, multi=0. Held with ready=0 for 5 cycles -> all outputs unchanged.
REQ-028 Fixed priority (macro undefined): in1=in3=1 -> code 01 with multi=1. Then ready=1 with the requests held -> the next code is 01 again, with no idle cycle between.
REQ-029 Round-robin (macro defined): in0..in3 all 1, ready=1 continuously -> codes 00, 01, 10, 11, 00 on consecutive cycles, with multi=1 throughout.
REQ-030 enable=0 with in0=1 in IDLE for 3 cycles -> valid stays 0. Raise enable -> valid=1 with code 00 one edge later.
REQ-031 Drain: in HOLD, drop every request, then ready=1 -> valid=0 at that edge and the state is IDLE.

Source files
------------

// File: rtl/request_encoder_pkg.sv
// rtl/request_encoder_pkg.sv - shared sizes and FSM state type for request_encoder
package request_encoder_pkg;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/priority_pick4.sv
// rtl/priority_pick4.sv - rotating-start 4-way pick with any/multi flags
module priority_pick4
    import request_encoder_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ADDR_W-1:0]  start,
    output logic [ADDR_W-1:0]  winner,
    output logic               any,
    output logic               multi
);

    logic [ADDR_W-1:0] idx;
    logic [2:0]        count;

    // Search start, start+1, ... modulo 4; the first high line wins.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = start + i[ADDR_W-1:0];
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

    // Popcount of the request lines; two or more means contention.
    always_comb begin
        count = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            count = count + {2'b00, req[i]};
        end
        multi = (count >= 3'd2);
    end

endmodule

// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - registered 4:2 request encoder with valid/ready hold; REQUEST_ENCODER_RR_EN enables round-robin
module request_encoder
    import request_encoder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic in0,
    input  logic in1,
    input  logic in2,
    input  logic in3,
    input  logic ready,
    output logic address0,
    output logic address1,
    output logic valid,
    output logic multi
);

    state_t              state;
    state_t              state_next;
    logic [NUM_REQ-1:0]  req;
    logic [ADDR_W-1:0]   code;
    logic [ADDR_W-1:0]   start;
    logic [ADDR_W-1:0]   winner;
    logic                any_req;
    logic                multi_pick;
    logic                multi_q;
    logic                capture;
    logic                consume;

    assign req     = {in3, in2, in1, in0};
    assign consume = (state == HOLD) && ready;

`ifdef REQUEST_ENCODER_RR_EN
    logic [ADDR_W-1:0] ptr;

    // A grant consumed at this edge already moves the search start for a back-to-back capture.
    assign start = consume ? (code + 2'd1) : ptr;

    // Pointer advances past each consumed grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (consume) begin
            ptr <= code + 2'd1;
        end
    end
`else
    assign start = '0;
`endif

    priority_pick4 u_pick (
        .req    (req),
        .start  (start),
        .winner (winner),
        .any    (any_req),
        .multi  (multi_pick)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and capture decision; ready only matters while holding a code.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (enable && any_req) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (enable && any_req) begin
                        capture = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Code and multi registers load only on a capture; otherwise they keep the last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code    <= '0;
            multi_q <= 1'b0;
        end else if (capture) begin
            code    <= winner;
            multi_q <= multi_pick;
        end
    end

    assign address0 = code[0];
    assign address1 = code[1];
    assign multi    = multi_q;
    assign valid    = (state == HOLD);

endmodule
